// File: rtl/lsu_pkg.sv
// Shared load/store encodings and FSM state type for the LSU memory controller
// and the downstream load_data_path.
package lsu_pkg;

  localparam logic [2:0] LOAD_BYTE  = 3'b000;
  localparam logic [2:0] LOAD_HALF  = 3'b001;
  localparam logic [2:0] LOAD_WORD  = 3'b010;
  localparam logic [2:0] LOAD_BYTEU = 3'b100;
  localparam logic [2:0] LOAD_HALFU = 3'b101;

  localparam logic [2:0] STORE_B = 3'b000;
  localparam logic [2:0] STORE_H = 3'b001;
  localparam logic [2:0] STORE_W = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (f3)
        STORE_B, STORE_H, STORE_W: bad = 1'b0;
        default:                   bad = 1'b1;
      endcase
    end else begin
      case (f3)
        LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTEU, LOAD_HALFU: bad = 1'b0;
        default:                                                 bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane steering: byte enables, replicated store data and
// natural-alignment check for the access size encoded in funct3[1:0].
module lsu_store_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  // Loads always read the full word; extraction happens in load_data_path.
  always_comb begin
    o_be       = 4'b1111;
    o_wdata    = 32'd0;
    o_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        if (i_we) begin
          o_be    = 4'b0001 << i_offset;
          o_wdata = {4{i_wdata[7:0]}};
        end
      end
      2'b01: begin
        o_misalign = i_offset[0];
        if (i_we) begin
          o_be    = 4'b0011 << i_offset;
          o_wdata = {2{i_wdata[15:0]}};
        end
      end
      2'b10: begin
        o_misalign = (i_offset != 2'b00);
        if (i_we) o_wdata = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one request, checks it, runs the memory
// valid/ready handshake and returns a one-cycle registered response.
//
// state    | meaning
// ST_IDLE  | ready for a new request
// ST_ISSUE | memory request held on o_mem_* until i_mem_ready
// ST_WAIT  | load issued, waiting for i_mem_rvalid or timeout
// ST_RESP  | o_rsp_valid pulse with registered response fields
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [2:0]        i_req_funct3,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic [1:0]        o_rsp_offset,
  output logic [2:0]        o_rsp_load_type,
  output logic              o_rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        r_state, w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_offset;
  logic [2:0]        r_funct3;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rsp_rdata;
  logic [1:0]        r_rsp_offset;
  logic [2:0]        r_rsp_type;
  logic              r_rsp_err;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign, w_bad, w_accept, w_timeout, w_issue;

  lsu_store_align u_align (
    .i_we       (i_req_we),
    .i_funct3   (i_req_funct3),
    .i_offset   (i_req_addr[1:0]),
    .i_wdata    (i_req_wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  assign w_accept  = i_req_valid && (r_state == ST_IDLE);
  assign w_bad     = w_misalign || funct3_illegal(i_req_we, i_req_funct3);
  // Counter value before this cycle's increment; the increment reaching TIMEOUT ends the wait.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_bad ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (i_mem_ready) w_state_nxt = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (i_mem_rvalid || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_offset     <= 2'd0;
      r_funct3     <= 3'd0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_cnt        <= '0;
      r_rsp_rdata  <= 32'd0;
      r_rsp_offset <= 2'd0;
      r_rsp_type   <= 3'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we     <= i_req_we;
            r_addr   <= {i_req_addr[ADDR_W-1:2], 2'b00};
            r_offset <= i_req_addr[1:0];
            r_funct3 <= i_req_funct3;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            if (w_bad) begin
              r_rsp_rdata  <= 32'd0;
              r_rsp_offset <= i_req_addr[1:0];
              r_rsp_type   <= i_req_funct3;
              r_rsp_err    <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (i_mem_ready) begin
            r_cnt <= '0;
            if (r_we) begin
              r_rsp_rdata  <= 32'd0;
              r_rsp_offset <= r_offset;
              r_rsp_type   <= r_funct3;
              r_rsp_err    <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid || w_timeout) begin
            r_rsp_rdata  <= i_mem_rvalid ? i_mem_rdata : 32'd0;
            r_rsp_offset <= r_offset;
            r_rsp_type   <= r_funct3;
            r_rsp_err    <= !i_mem_rvalid;
          end
          if (!i_mem_rvalid) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_issue         = (r_state == ST_ISSUE);
  assign o_req_ready     = (r_state == ST_IDLE);
  assign o_mem_valid     = w_issue;
  assign o_mem_we        = w_issue && r_we;
  assign o_mem_addr      = w_issue ? r_addr : '0;
  assign o_mem_be        = w_issue ? r_be : 4'd0;
  assign o_mem_wdata     = w_issue ? r_wdata : 32'd0;
  assign o_rsp_valid     = (r_state == ST_RESP);
  assign o_rsp_rdata     = r_rsp_rdata;
  assign o_rsp_offset    = r_rsp_offset;
  assign o_rsp_load_type = r_rsp_type;
  assign o_rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a transaction-level expectation model
// and a per-cycle monitor on the memory and response interfaces.
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic [2:0]  i_req_funct3 = 3'd0;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_offset;
  logic [2:0]  o_rsp_load_type;
  logic        o_rsp_err;

  always #5 i_clk = ~i_clk;

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_funct3(i_req_funct3),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_offset(o_rsp_offset),
    .o_rsp_load_type(o_rsp_load_type), .o_rsp_err(o_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  // Expectations for the transaction in flight
  logic        exp_access = 1'b0;
  logic        exp_rsp_on = 1'b0;
  logic        exp_we = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic [3:0]  exp_be = 4'd0;
  logic [1:0]  exp_off = 2'd0;
  logic [2:0]  exp_type = 3'd0;

  logic [31:0] seen_addr = 32'd0;
  logic [31:0] seen_wdata = 32'd0;
  logic [3:0]  seen_be = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected behaviour from access size, alignment and legality rules
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] rd, input bit rv_arrives);
    int  size;
    bit  illegal, mis;
    illegal    = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    size       = 1 << f3[1:0];
    mis        = !illegal && ((int'(addr[1:0]) % size) != 0);
    exp_access = !illegal && !mis;
    exp_we     = we;
    exp_addr   = addr & ~32'd3;
    exp_be     = we ? 4'(((1 << size) - 1) << addr[1:0]) : 4'hF;
    case (size)
      1:       exp_wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
      2:       exp_wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
      default: exp_wdata = wd;
    endcase
    exp_err   = !exp_access || (!we && !rv_arrives);
    exp_rdata = (!we && !exp_err) ? rd : 32'd0;
    exp_off   = addr[1:0];
    exp_type  = f3;
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_mem_valid) begin
        check("mem_valid_allowed", 32'(o_mem_valid), 32'(exp_access));
        check("mem_addr", o_mem_addr, exp_addr);
        check("mem_we", 32'(o_mem_we), 32'(exp_we));
        check("mem_be", 32'(o_mem_be), 32'(exp_be));
        if (exp_we) check("mem_wdata", o_mem_wdata, exp_wdata);
      end
      if (o_rsp_valid) begin
        check("rsp_allowed", 32'(o_rsp_valid), 32'(exp_rsp_on));
        check("rsp_rdata", o_rsp_rdata, exp_rdata);
        check("rsp_offset", 32'(o_rsp_offset), 32'(exp_off));
        check("rsp_type", 32'(o_rsp_load_type), 32'(exp_type));
        check("rsp_err", 32'(o_rsp_err), 32'(exp_err));
      end
    end
  end

  task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd, input int rdy_dly,
                         input int rv_dly, input logic [31:0] rd, input int exp_lat);
    int hs, vcnt, lat;
    model(we, addr, f3, wd, rd, rv_dly >= 0);
    @(negedge i_clk);
    exp_rsp_on = 1'b1;
    check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_funct3 = f3; i_req_wdata = wd;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_addr = 32'hFFFF_FFFF; i_req_wdata = 32'h5A5A_5A5A;
    hs = -1; vcnt = 0; lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (c > 1) @(negedge i_clk);
      i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'hBAD0_BAD0;
      if (o_rsp_valid) lat = c;
      else if (o_mem_valid) begin
        if (vcnt == rdy_dly) begin i_mem_ready = 1'b1; hs = c; end
        vcnt++;
        seen_addr = o_mem_addr; seen_be = o_mem_be; seen_wdata = o_mem_wdata;
      end else if (!we && hs > 0 && rv_dly >= 0 && c == hs + 1 + rv_dly) begin
        i_mem_rvalid = 1'b1; i_mem_rdata = rd;
      end
    end
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_mem_cycles"}, vcnt, exp_access ? rdy_dly + 1 : 0);
    @(negedge i_clk);
    exp_rsp_on = 1'b0;
    check({tag, "_rsp_pulse"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(o_req_ready), 32'd1);
    check({tag, "_rsp_hold"}, o_rsp_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_mem_valid", 32'(o_mem_valid), 32'd0);
    check("rst_mem_we", 32'(o_mem_we), 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_be", 32'(o_mem_be), 32'd0);
    check("rst_mem_wdata", o_mem_wdata, 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    i_rst_n = 1'b1;

    run_txn("lw", 1'b0, 32'h100, 3'b010, 32'd0, 0, 0, 32'hDEAD_BEEF, 3);
    check("lw_addr_lit", seen_addr, 32'h100);
    check("lw_be_lit", 32'(seen_be), 32'hF);
    check("lw_rdata_lit", o_rsp_rdata, 32'hDEAD_BEEF);

    run_txn("sb", 1'b1, 32'h203, 3'b000, 32'h0000_00A5, 0, 0, 32'd0, 2);
    check("sb_addr_lit", seen_addr, 32'h200);
    check("sb_be_lit", 32'(seen_be), 32'b1000);
    check("sb_wdata_lit", seen_wdata, 32'hA5A5_A5A5);

    run_txn("lh_mis", 1'b0, 32'h101, 3'b001, 32'd0, 0, 0, 32'd0, 1);
    check("lh_mis_err_lit", 32'(o_rsp_err), 32'd1);
    run_txn("lw_mis", 1'b0, 32'h102, 3'b010, 32'd0, 0, 0, 32'd0, 1);
    run_txn("sw_mis", 1'b1, 32'h206, 3'b010, 32'h1111_2222, 0, 0, 32'd0, 1);
    run_txn("st_ill", 1'b1, 32'h200, 3'b100, 32'h1111_2222, 0, 0, 32'd0, 1);
    run_txn("ld_ill", 1'b0, 32'h200, 3'b110, 32'd0, 0, 0, 32'd0, 1);

    run_txn("lbu_stall", 1'b0, 32'h302, 3'b100, 32'd0, 3, 0, 32'h1122_3344, 6);
    check("lbu_addr_lit", seen_addr, 32'h300);
    check("lbu_off_lit", 32'(o_rsp_offset), 32'd2);

    run_txn("lw_tmo", 1'b0, 32'h400, 3'b010, 32'd0, 0, -1, 32'd0, 2 + TO);
    check("tmo_rdata_lit", o_rsp_rdata, 32'd0);
    check("tmo_err_lit", 32'(o_rsp_err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_5555;
      check("stray_rvalid_no_rsp", 32'(o_rsp_valid), 32'd0);
    end
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    check("stray_rvalid_no_rsp", 32'(o_rsp_valid), 32'd0);

    run_txn("sh", 1'b1, 32'h402, 3'b001, 32'hABCD_1234, 0, 0, 32'd0, 2);
    check("sh_be_lit", 32'(seen_be), 32'b1100);
    check("sh_wdata_lit", seen_wdata, 32'h1234_1234);
    run_txn("lhu_slow", 1'b0, 32'h502, 3'b101, 32'd0, 1, 2, 32'hCAFE_F00D, 6);
    run_txn("sw", 1'b1, 32'h504, 3'b010, 32'h0BAD_CAFE, 2, 0, 32'd0, 4);

    // Abort a load while it waits for read data
    model(1'b0, 32'h601, 3'b000, 32'd0, 32'd0, 1'b1);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h601; i_req_funct3 = 3'b000;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    for (int c = 0; c < 10 && !o_mem_valid; c++) @(negedge i_clk);
    check("abort_issue_seen", 32'(o_mem_valid), 32'd1);
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    check("abort_in_wait_ready", 32'(o_req_ready), 32'd0);
    #2;
    i_rst_n = 1'b0;
    exp_access = 1'b0;
    #1;
    check("abort_mem_valid", 32'(o_mem_valid), 32'd0);
    check("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("abort_rsp_rdata", o_rsp_rdata, 32'd0);
    check("abort_rsp_type", 32'(o_rsp_load_type), 32'd0);
    check("abort_req_ready", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h7777_7777;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("late_rvalid_no_rsp", 32'(o_rsp_valid), 32'd0);
      check("late_rvalid_ready", 32'(o_req_ready), 32'd1);
    end
    i_mem_rvalid = 1'b0;

    run_txn("post_rst_lb", 1'b0, 32'h703, 3'b000, 32'd0, 0, 0, 32'h89AB_CDEF, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
